// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by uart_rx and uart_tx.
// Includes the receiver state encoding and the bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } uart_rx_state_t;

  function automatic int bit_cycles(input int clock_freq,
                                    input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops reset to RESET_VAL.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, valid/ready output, framing/overrun pulses.
// Define UART_RX_PARITY_EN to add a parity bit, PARITY_ODD and parity_error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 overrun
);

  localparam int BIT_CYCLES  = bit_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic                 rx_s;
  logic                 armed;
  logic [CW-1:0]        clock_count;
  logic [BW-1:0]        bit_count;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_done;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
`endif

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign bit_done = (clock_count == BIT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      clock_count <= '0;
      bit_count   <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_busy     <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          // a held-low line must go high once before a new start counts
          if (!armed) begin
            armed <= rx_s;
          end else if (!rx_s) begin
            state       <= START;
            clock_count <= '0;
            rx_busy     <= 1'b1;
          end
        end
        START: begin
          if (clock_count == HALF_LAST) begin
            clock_count <= '0;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state     <= DATA;
              bit_count <= '0;
`ifdef UART_RX_PARITY_EN
              parity_bad <= 1'b0;
`endif
            end
          end else begin
            clock_count <= clock_count + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            clock_count <= '0;
            shift       <= {rx_s, shift[DATA_BITS-1:1]};
            bit_count   <= bit_count + 1'b1;
            if (bit_count == DATA_LAST) begin
              bit_count <= '0;
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            clock_count <= clock_count + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            clock_count <= '0;
            parity_bad  <= rx_s ^ (^shift) ^ PARITY_ODD;
            state       <= STOP;
          end else begin
            clock_count <= clock_count + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            clock_count <= '0;
            state       <= IDLE;
            rx_busy     <= 1'b0;
            armed       <= 1'b0;
            if (!rx_s) begin
              frame_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad) begin
              parity_error <= 1'b1;
`endif
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            clock_count <= clock_count + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
// Define UART_RX_PARITY_EN to also exercise the parity path.
module tb_uart_rx;

  localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 155 + BIT;
`else
  localparam int LAT = 155;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_busy;
  logic       frame_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = 0;
  int rise_cyc = 0;
  int vrise = 0;
  int vhigh = 0;
  int fe_cnt = 0;
  int ovr_cnt = 0;
  int pe_cnt = 0;
  int busy_cnt = 0;
  int long_cnt = 0;
  int both_cnt = 0;
  logic valid_q = 1'b0;
  logic fe_q = 1'b0;
  logic ovr_q = 1'b0;
  int snap;

  uart_rx #(
    .BAUD_RATE (10),
    .CLOCK_FREQ(160),
    .DATA_BITS (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .frame_error (frame_error),
`ifdef UART_RX_PARITY_EN
    .parity_error(parity_error),
`endif
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (rx_valid && !valid_q) begin
      vrise++;
      rise_cyc = cyc;
    end
    if (rx_valid) vhigh++;
    if (frame_error) fe_cnt++;
    if (overrun) ovr_cnt++;
    if (rx_busy) busy_cnt++;
    if ((frame_error && fe_q) || (overrun && ovr_q)) long_cnt++;
    if (frame_error && overrun) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_error) pe_cnt++;
`endif
    valid_q = rx_valid;
    fe_q    = frame_error;
    ovr_q   = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input logic par_bad);
    @(negedge clock);
    rx = 1'b0;
    t_start = cyc;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT) @(negedge clock);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ par_bad;
    repeat (BIT) @(negedge clock);
`else
    if (par_bad) rx = 1'b1;
`endif
    rx = stop;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic consume();
    @(negedge clock);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("rst_fe", {31'd0, frame_error}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // 0xA5, not consumed
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_data", {24'd0, rx_data}, 32'hA5);
    chk("a5_valid", {31'd0, rx_valid}, 32'd1);
    chk("a5_lat", rise_cyc - t_start, LAT);
    chk("a5_fe", fe_cnt, 0);
    chk("a5_ovr", ovr_cnt, 0);
    consume();
    chk("a5_clear", {31'd0, rx_valid}, 32'd0);

    // overrun: second word dropped
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    chk("ovr_data", {24'd0, rx_data}, 32'h3C);
    chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr_cnt", ovr_cnt, 1);
    consume();

    // ready held high
    rx_ready = 1'b1;
    vhigh = 0;
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    rx_ready = 1'b0;
    chk("ff_vhigh", vhigh, 1);
    chk("ff_data", {24'd0, rx_data}, 32'hFF);
    chk("ff_valid", {31'd0, rx_valid}, 32'd0);

    // false start
    snap = vrise;
    @(negedge clock);
    rx = 1'b0;
    repeat (5) @(negedge clock);
    rx = 1'b1;
    chk("fs_busy_on", {31'd0, rx_busy}, 32'd1);
    repeat (30) @(negedge clock);
    chk("fs_busy_off", {31'd0, rx_busy}, 32'd0);
    chk("fs_vrise", vrise - snap, 0);
    chk("fs_fe", fe_cnt, 0);

    // bad stop, then line held low
    send_frame(8'h55, 1'b0, 1'b0);
    snap = busy_cnt;
    repeat (100) @(negedge clock);
    chk("fe_cnt", fe_cnt, 1);
    chk("fe_valid", {31'd0, rx_valid}, 32'd0);
    chk("fe_rearm", busy_cnt - snap, 0);
    rx = 1'b1;
    repeat (20) @(negedge clock);

    // reset mid-frame
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("pre_valid", {31'd0, rx_valid}, 32'd1);
    chk("pre_data", {24'd0, rx_data}, 32'h5A);
    @(negedge clock);
    rx = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h12 >> i);
      repeat (BIT) @(negedge clock);
    end
    rx = 1'b0;
    repeat (8) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mr_valid", {31'd0, rx_valid}, 32'd0);
    chk("mr_data", {24'd0, rx_data}, 32'd0);
    chk("mr_busy", {31'd0, rx_busy}, 32'd0);
    chk("mr_pulse", {30'd0, frame_error, overrun}, 32'd0);
    @(negedge clock);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    send_frame(8'h34, 1'b1, 1'b0);
    chk("post_data", {24'd0, rx_data}, 32'h34);
    chk("post_valid", {31'd0, rx_valid}, 32'd1);
    chk("post_fe", fe_cnt, 1);
    consume();

`ifdef UART_RX_PARITY_EN
    snap = vrise;
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par_pe", pe_cnt, 1);
    chk("par_vrise", vrise - snap, 0);
`endif

    chk("pulse_width", long_cnt, 0);
    chk("pulse_both", both_cnt, 0);
    chk("ovr_total", ovr_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: the downstream stage of uart_tx. It consumes the tx line and recovers 8N1-style frames: start bit, DATA_BITS data bits LSB first, one stop bit.
- It samples each bit at its midpoint and presents each byte on a valid/ready handshake to the consuming logic.
- It flags framing errors and overruns.

Parameters:
- BAUD_RATE, 9600, line bit rate.
- CLOCK_FREQ, 50000000, clock frequency in Hz.
- DATA_BITS, 8, data bits per frame.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clock, idle high.
- rx_data  output  DATA_BITS  last good received word, LSB = first data bit.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- rx_busy  output  1  high while a frame is in progress (states other than IDLE).
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good frame completed while rx_valid still high.

Behaviour:
- Constants:
  - BIT_CYCLES = CLOCK_FREQ/BAUD_RATE (integer divide).
  - HALF_CYCLES = BIT_CYCLES/2.
  - Counters are sized $clog2(BIT_CYCLES+1) and $clog2(DATA_BITS+1). No int registers.
- Synchronizer: rx passes through 2 flops, both reset to 1, giving rx_s. All decisions use rx_s. This adds 2 cycles of latency.
- Reset values:
  - state=IDLE, rx_data=0, rx_valid=0, rx_busy=0.
  - frame_error=0, overrun=0.
  - All counters and the shift register = 0.
- Reset takes effect immediately at any point, including mid-frame. The partial frame is discarded and no pulse is issued.
- States: IDLE, START, DATA, STOP, plus PARITY when the optional feature is enabled.
- IDLE:
  - Arms only after rx_s has been seen high at least one cycle since reset or since the last frame ended. This prevents a held-low break from retriggering.
  - When armed and rx_s==0: clear clock_count and go to START.
- START:
  - Counts to HALF_CYCLES-1.
  - At HALF_CYCLES-1, resample rx_s. If 1, the start is false: return to IDLE with no pulse. If 0, clear counters and go to DATA.
- DATA:
  - Counts to BIT_CYCLES-1, then samples rx_s into the shift register MSB and shifts right. This puts the first bit at the LSB after DATA_BITS samples.
  - After the DATA_BITS-th sample, go to STOP (or PARITY).
- STOP:
  - Counts to BIT_CYCLES-1, then samples rx_s and returns to IDLE (disarmed).
  - If the sample is 0: frame_error=1 for one cycle. rx_data and rx_valid are unchanged.
  - If the sample is 1 and rx_valid==0 (or is being accepted this same cycle): load rx_data and set rx_valid=1 the next cycle.
  - If the sample is 1 and rx_valid==1 with rx_ready==0: overrun=1 for one cycle. The old rx_data is kept and the new word is dropped.
- Handshake:
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - If a load and an accept happen in the same cycle, the load wins: rx_valid stays 1 with the new data.
  - rx_ready is ignored when rx_valid==0.
- Pulses: frame_error and overrun are never asserted together and never for more than one cycle.
- Sample points, relative to the falling start edge as seen at rx_s: HALF_CYCLES, then +k*BIT_CYCLES for k = 1..DATA_BITS+1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds parameter PARITY_ODD (default 0 = even) and output parity_error (one-cycle pulse).
  - A PARITY state between DATA and STOP samples one extra bit after BIT_CYCLES.
  - A mismatch against the XOR of the data bits (inverted if PARITY_ODD) latches an internal flag. At the stop sample, a good stop bit with the flag set pulses parity_error and does not load rx_data. A bad stop bit reports frame_error only.
- When undefined: no PARITY state, no parity_error port, frame = start + data + stop.

Decomposition:
- Package uart_pkg:
  - state typedef uart_rx_state_t (IDLE, START, DATA, STOP, PARITY).
  - Function bit_cycles(clock_freq, baud_rate).
  - Shared with uart_tx.
- Sub-module sync_2ff: 2-flop synchronizer with reset value parameter RESET_VAL=1.

Test Plan:
(Use CLOCK_FREQ=160, BAUD_RATE=10, so BIT_CYCLES=16; drive rx with a uart_tx instance or a bench model.)
- Send 0xA5 with rx_ready=0 -> rx_valid rises about 8+16*9+3 cycles after the start edge, rx_data=0xA5, frame_error=0, overrun=0.
- Send 0x3C then 0x81 with rx_ready=0 throughout -> rx_data stays 0x3C, one overrun pulse at the end of the second frame.
- Send 0xFF with rx_ready=1 -> rx_valid high for exactly 1 cycle, rx_data=0xFF.
- rx low for 5 cycles, then high -> START aborts, rx_busy falls, no rx_valid, no frame_error.
- Frame 0x55 with stop bit forced 0, then rx held low 100 cycles -> one frame_error pulse, rx_valid stays 0, no new frame until rx returns high.
- Assert reset during the 4th data bit of 0x12 -> all outputs 0 immediately. A following clean frame 0x34 is received correctly. With UART_RX_PARITY_EN, send 0x07 with a wrong even-parity bit -> parity_error pulse and no rx_valid.
